// File: rtl/ulpi_phy_responder_pkg.sv
// ulpi_phy_responder_pkg: shared TX CMD codes, register map, reset values and FSM encoding
package ulpi_pkg;
  localparam logic [1:0] CMD_WR = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b11;
  localparam logic [5:0] ADDR_EXT = 6'h2F;
  localparam logic [15:0] VENDOR_ID = 16'h0424;
  localparam logic [15:0] PRODUCT_ID = 16'h0006;
  localparam int NREG = 4;
  localparam logic [5:0] REG_BASE [NREG] = '{6'h04, 6'h07, 6'h0A, 6'h16};
  localparam logic [7:0] REG_RST [NREG] = '{8'h41, 8'h00, 8'h06, 8'h00};
  typedef enum logic [3:0] {
    IDLE, CMD_ACK, WR_DATA, WR_STP,
    RD_TURN1, RD_DATA, RD_TURN2,
    RX_TURN1, RX_DATA, RX_TURN2
  } state_t;
  function automatic logic is_cmd(logic [7:0] b);
    return (b[7:6] == CMD_WR || b[7:6] == CMD_RD) && b[5:0] != ADDR_EXT;
  endfunction
  function automatic logic [7:0] alias_update(logic [1:0] op, logic [7:0] cur, logic [7:0] d);
    return op == 2'd0 ? d : op == 2'd1 ? (cur | d) : (cur & ~d);
  endfunction
endpackage

// File: rtl/ulpi_phy_responder_if.sv
// ulpi_phy_responder_if: ULPI signals between link controller and PHY
interface ulpi_phy_responder_if;
  logic [7:0] data_in;
  logic       stp;
  logic [1:0] linestate;
  logic       dir;
  logic       nxt;
  logic [7:0] data_out;
  logic       data_oe;
  modport master (output data_in, stp, linestate, input dir, nxt, data_out, data_oe);
  modport slave (input data_in, stp, linestate, output dir, nxt, data_out, data_oe);
endinterface

// File: rtl/ulpi_phy_responder_regfile.sv
// ulpi_phy_regfile: four R/W registers with write/set/clear aliases, IDs and read mux
module ulpi_phy_regfile
  import ulpi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] vals [NREG];
  logic [NREG-1:0] hits;
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic [5:0] off;
    logic [7:0] q;
    // offset from the base selects write/set/clear; addresses below the base wrap and miss
    assign off = addr - REG_BASE[g];
    assign hits[g] = off < 6'd3;
    assign vals[g] = q;
    // apply the aliased operation on a committed write hitting this register
    always_ff @(posedge clk)
      if (rst) q <= REG_RST[g];
      else if (we && hits[g]) q <= alias_update(off[1:0], q, wdata);
  end
  // read mux: IDs, then any alias of a register, otherwise zero
  always_comb begin
    rdata = addr == 6'h00 ? VENDOR_ID[7:0] :
            addr == 6'h01 ? VENDOR_ID[15:8] :
            addr == 6'h02 ? PRODUCT_ID[7:0] :
            addr == 6'h03 ? PRODUCT_ID[15:8] : 8'h00;
    for (int i = 0; i < NREG; i++)
      if (hits[i]) rdata = vals[i];
  end
endmodule

// File: rtl/ulpi_phy_responder.sv
// ulpi_phy_responder: PHY-side ULPI register access and RX CMD generation
module ulpi_phy_responder
  import ulpi_pkg::*;
(
  input logic clk,
  input logic rst,
  ulpi_phy_responder_if.slave bus
);
  state_t state, state_nx;
  logic [1:0] ls_meta, ls_sync, cap, reported;
  logic [5:0] addr;
  logic       rd;
  logic [7:0] wdata, rdata;
  logic       cmd_ok, rx_pend, we;
  assign cmd_ok = is_cmd(bus.data_in);
  assign rx_pend = ls_sync != reported;
  assign we = state == WR_STP && bus.stp;
  ulpi_phy_regfile u_regs (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
  // two-flop synchronizer for the asynchronous line state
  always_ff @(posedge clk)
    {ls_sync, ls_meta} <= rst ? 4'b0 : {ls_meta, bus.linestate};
  // next-state logic; commands take priority over a pending RX CMD
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = cmd_ok ? CMD_ACK : rx_pend ? RX_TURN1 : IDLE;
      CMD_ACK:  state_nx = bus.stp ? IDLE : rd ? RD_TURN1 : WR_DATA;
      WR_DATA:  state_nx = bus.stp ? IDLE : WR_STP;
      WR_STP:   state_nx = bus.stp ? IDLE : WR_STP;
      RD_TURN1: state_nx = RD_DATA;
      RD_DATA:  state_nx = RD_TURN2;
      RX_TURN1: state_nx = RX_DATA;
      RX_DATA:  state_nx = RX_TURN2;
      default:  state_nx = IDLE;
    endcase
  end
  // state and bus outputs registered from the next state so they align with it
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bus.dir <= 1'b0;
      bus.nxt <= 1'b0;
      bus.data_oe <= 1'b0;
      bus.data_out <= 8'h00;
    end else begin
      state <= state_nx;
      bus.dir <= state_nx inside {RD_TURN1, RD_DATA, RX_TURN1, RX_DATA};
      bus.nxt <= state_nx inside {CMD_ACK, WR_DATA};
      bus.data_oe <= state_nx inside {RD_DATA, RX_DATA};
      bus.data_out <= state_nx == RD_DATA ? rdata : state_nx == RX_DATA ? {6'b0, ls_sync} : 8'h00;
    end
  // transaction datapath: command address, write data and line state reporting
  always_ff @(posedge clk)
    if (rst) begin
      addr <= 6'h00;
      rd <= 1'b0;
      wdata <= 8'h00;
      cap <= 2'b00;
      reported <= 2'b00;
    end else begin
      if (state == IDLE && cmd_ok) {rd, addr} <= bus.data_in[6:0];
      if (state == WR_DATA) wdata <= bus.data_in;
      if (state == RX_TURN1) cap <= ls_sync;
      if (state == RX_DATA) reported <= cap;
    end
endmodule

// File: tb/tb_ulpi_phy_responder.sv
// tb_ulpi_phy_responder: directed table-driven checks of the ULPI PHY responder
module tb_ulpi_phy_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passes = 0;
  typedef struct {
    logic       rd;
    logic [7:0] cmd;
    logic [7:0] val;
  } vec_t;
  vec_t vecs[$];
  ulpi_phy_responder_if bus ();
  ulpi_phy_responder dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %02h expected %02h", name, got, exp);
  endtask

  task automatic add(input logic r, input logic [7:0] c, input logic [7:0] v);
    vec_t e;
    e.rd = r;
    e.cmd = c;
    e.val = v;
    vecs.push_back(e);
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] d);
    string n;
    n = $sformatf("wr %02h", cmd);
    cyc(); bus.data_in = cmd; bus.stp = 1'b0;
    cyc(); bus.data_in = d; check({n, " nxt1"}, 8'(bus.nxt), 8'h01);
    cyc(); check({n, " nxt2"}, 8'(bus.nxt), 8'h01);
    cyc(); bus.data_in = 8'h00; bus.stp = 1'b1; check({n, " stp nxt"}, 8'(bus.nxt), 8'h00);
    cyc(); bus.stp = 1'b0; check({n, " end dir"}, 8'(bus.dir), 8'h00);
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [7:0] exp, input logic [1:0] ls_ack);
    string n;
    n = $sformatf("rd %02h", cmd);
    cyc(); bus.data_in = cmd; bus.stp = 1'b0;
    cyc(); bus.data_in = 8'h00; bus.linestate = ls_ack;
    check({n, " ack nxt"}, 8'(bus.nxt), 8'h01);
    check({n, " ack dir"}, 8'(bus.dir), 8'h00);
    cyc(); check({n, " turn1 dir"}, 8'(bus.dir), 8'h01); check({n, " turn1 oe"}, 8'(bus.data_oe), 8'h00);
    cyc(); check({n, " data dir"}, 8'(bus.dir), 8'h01); check({n, " data oe"}, 8'(bus.data_oe), 8'h01);
    check({n, " data"}, bus.data_out, exp);
    cyc(); check({n, " turn2 dir"}, 8'(bus.dir), 8'h00); check({n, " turn2 oe"}, 8'(bus.data_oe), 8'h00);
  endtask

  task automatic expect_rx(input string n, input logic [7:0] exp);
    cyc(); check({n, " rx turn1 dir"}, 8'(bus.dir), 8'h01); check({n, " rx turn1 oe"}, 8'(bus.data_oe), 8'h00);
    cyc(); check({n, " rx data oe"}, 8'(bus.data_oe), 8'h01); check({n, " rx data"}, bus.data_out, exp);
    cyc(); check({n, " rx turn2 dir"}, 8'(bus.dir), 8'h00);
  endtask

  initial begin
    bus.data_in = 8'h00;
    bus.stp = 1'b0;
    bus.linestate = 2'b00;
    repeat (3) cyc();
    check("reset dir", 8'(bus.dir), 8'h00);
    check("reset nxt", 8'(bus.nxt), 8'h00);
    check("reset oe", 8'(bus.data_oe), 8'h00);
    check("reset data_out", bus.data_out, 8'h00);
    rst = 1'b0;
    foreach (vecs[i]) vecs.delete();
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.data_in = i == 0 ? 8'h00 : i == 1 ? 8'h45 : 8'hAF;
      cyc(); bus.data_in = 8'h00; check($sformatf("ignored %0d nxt", i), 8'(bus.nxt), 8'h00);
    end
    add(1, 8'hC0, 8'h24); add(1, 8'hC1, 8'h04); add(1, 8'hC2, 8'h06); add(1, 8'hC3, 8'h00);
    add(1, 8'hC4, 8'h41); add(1, 8'hC7, 8'h00); add(1, 8'hCA, 8'h06); add(1, 8'hD6, 8'h00);
    add(0, 8'h84, 8'h55); add(1, 8'hC4, 8'h55); add(1, 8'hC5, 8'h55);
    add(0, 8'h85, 8'h0A); add(1, 8'hC6, 8'h5F); add(0, 8'h86, 8'h01); add(1, 8'hC4, 8'h5E);
    add(0, 8'h80, 8'hFF); add(1, 8'hC0, 8'h24); add(1, 8'hE0, 8'h00);
    add(0, 8'h97, 8'hF0); add(1, 8'hD6, 8'hF0); add(0, 8'h98, 8'h30); add(1, 8'hD8, 8'hC0);
    add(0, 8'h8C, 8'h02); add(1, 8'hCA, 8'h04);
    add(0, 8'h87, 8'hA5); add(1, 8'hC8, 8'hA5); add(0, 8'h88, 8'h0A); add(1, 8'hC9, 8'hAF);
    add(0, 8'h89, 8'hA0); add(1, 8'hC7, 8'h0F);
    add(0, 8'h90, 8'h33); add(1, 8'hD0, 8'h00); add(0, 8'h99, 8'h11); add(1, 8'hD9, 8'h00);
    add(1, 8'hD5, 8'h00);
    foreach (vecs[i])
      if (vecs[i].rd) do_read(vecs[i].cmd, vecs[i].val, bus.linestate);
      else do_write(vecs[i].cmd, vecs[i].val);
    cyc(); bus.linestate = 2'b01;
    cyc(); check("idle rx lat1 dir", 8'(bus.dir), 8'h00);
    cyc(); check("idle rx lat2 dir", 8'(bus.dir), 8'h00);
    expect_rx("idle", 8'h01);
    cyc(); check("idle rx once dir", 8'(bus.dir), 8'h00);
    cyc(); bus.linestate = 2'b11; bus.data_in = 8'hC2;
    cyc(); bus.data_in = 8'h00; check("busy rd ack nxt", 8'(bus.nxt), 8'h01);
    cyc(); check("busy rd turn1 dir", 8'(bus.dir), 8'h01);
    cyc(); check("busy rd data", bus.data_out, 8'h06);
    cyc(); check("busy rd turn2 dir", 8'(bus.dir), 8'h00);
    cyc(); check("busy idle gap dir", 8'(bus.dir), 8'h00);
    expect_rx("busy", 8'h03);
    cyc(); bus.linestate = 2'b10;
    cyc(); check("race pre dir", 8'(bus.dir), 8'h00);
    do_read(8'hC0, 8'h24, 2'b10);
    cyc(); check("race idle gap dir", 8'(bus.dir), 8'h00);
    expect_rx("race", 8'h02);
    cyc(); bus.linestate = 2'b01;
    do_read(8'hC3, 8'h00, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc(); check($sformatf("bounce no rx %0d", i), 8'(bus.dir), 8'h00);
    end
    bus.linestate = 2'b00;
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    do_write(8'h85, 8'h0A);
    do_write(8'h86, 8'h01);
    do_read(8'hC4, 8'h4A, 2'b00);
    cyc(); bus.data_in = 8'h96;
    cyc(); bus.data_in = 8'hAA; bus.stp = 1'b1; check("abort ack nxt", 8'(bus.nxt), 8'h01);
    cyc(); bus.stp = 1'b0; bus.data_in = 8'h00; check("abort ack nxt off", 8'(bus.nxt), 8'h00);
    do_read(8'hD6, 8'h00, 2'b00);
    cyc(); bus.data_in = 8'h97;
    cyc(); bus.data_in = 8'h5A;
    cyc(); bus.stp = 1'b1; check("abort wd nxt", 8'(bus.nxt), 8'h01);
    cyc(); bus.stp = 1'b0; bus.data_in = 8'h00; check("abort wd nxt off", 8'(bus.nxt), 8'h00);
    cyc(); check("abort wd stp ignored", 8'(bus.nxt), 8'h00);
    do_read(8'hD6, 8'h00, 2'b00);
    cyc(); bus.data_in = 8'hC4;
    cyc(); bus.data_in = 8'h00;
    cyc();
    cyc(); check("rst rd data oe", 8'(bus.data_oe), 8'h01); rst = 1'b1;
    cyc(); rst = 1'b0;
    check("rst rd dir", 8'(bus.dir), 8'h00);
    check("rst rd oe", 8'(bus.data_oe), 8'h00);
    check("rst rd data_out", bus.data_out, 8'h00);
    do_read(8'hC4, 8'h41, 2'b00);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
